mem_arbiter: RTL and testbench

Two-port round-robin arbiter and access sequencer for the 32×8 data memory. It accepts read/write requests from two requesters (port 0: instruction fetch, port 1: data load/store). It serialises their requests onto the memory's single `address`/`data_in`/`read_write`/`data_out` interface and returns a one-cycle acknowledge with read data. It sits between the CPU core and the memory array, and is the only block that drives the memory's control inputs.

---
 rtl/mem_arbiter_if.sv | 36 +++
 rtl/mem_arbiter.sv | 110 +++++++++++
 tb/tb_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
interface mem_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              busy;
  logic              owner;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_read_write;
  logic [DATA_W-1:0] mem_data_out;

  // Requester/memory side of the bundle.
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    input  ack0, ack1, rdata0, rdata1, busy, owner, mem_address, mem_data_in, mem_read_write
  );

  // Arbiter side of the bundle.
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_data_out,
    output ack0, ack1, rdata0, rdata1, busy, owner, mem_address, mem_data_in, mem_read_write
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter that serialises requests onto a single-port memory.
// Each access takes IDLE -> ACCESS -> RESP; the ack is a registered one-cycle pulse in RESP.
module mem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              prio_q, prio_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;

  // State and datapath registers; reset wins over any pending update, including prio in RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      prio_q   <= 1'b0;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
    end
  end

  // Next-state logic: grant in IDLE, capture read data and raise ack in ACCESS, rotate in RESP.
  always_comb begin
    logic grant;
    grant    = 1'b0;
    state_d  = state_q;
    prio_d   = prio_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req0 || bus.req1) begin
          // Tie goes to prio; otherwise the lone requester wins.
          grant   = (bus.req0 && bus.req1) ? prio_q : bus.req1;
          owner_d = grant;
          we_d    = grant ? bus.we1    : bus.we0;
          addr_d  = grant ? bus.addr1  : bus.addr0;
          wdata_d = grant ? bus.wdata1 : bus.wdata0;
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (!we_q) begin
          if (owner_q) rdata1_d = bus.mem_data_out;
          else         rdata0_d = bus.mem_data_out;
        end
        if (owner_q) ack1_d = 1'b1;
        else         ack0_d = 1'b1;
        state_d = StResp;
      end
      StResp: begin
        prio_d  = ~owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Memory strobe is only asserted while the granted write is in ACCESS.
  assign bus.mem_read_write = (state_q == StAccess) && we_q;
  assign bus.mem_address    = addr_q;
  assign bus.mem_data_in    = wdata_q;
  assign bus.busy           = (state_q != StIdle);
  assign bus.owner          = owner_q;
  assign bus.ack0           = ack0_q;
  assign bus.ack1           = ack1_q;
  assign bus.rdata0         = rdata0_q;
  assign bus.rdata1         = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: transaction-timeline model plus directed and random stimulus.
module tb_mem_arbiter;
  localparam int AW = 5;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory array: asynchronous read, synchronous write.
  logic [DW-1:0] mem_arr [32] = '{default: '0};
  assign bus.mem_data_out = mem_arr[bus.mem_address];
  always @(posedge clk) if (bus.mem_read_write) mem_arr[bus.mem_address] <= bus.mem_data_in;

  // Reference model: one transaction in flight, timed by cycles since its grant.
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  int            rw_count = 0;
  bit            m_active = 1'b0;
  int            m_grant = 0;
  bit            m_port = 1'b0;
  bit            m_we = 1'b0;
  bit            m_prio = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rexp [2] = '{default: '0};
  logic [DW-1:0] shadow [32] = '{default: '0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // Apply the effect of the edge that ends the current cycle.
  task automatic model_advance();
    int d;
    d = cyc - m_grant;
    if (reset) begin
      if (m_active && d == 1 && m_we) shadow[m_addr] = m_wdata;
      m_active  = 1'b0;
      m_prio    = 1'b0;
      m_port    = 1'b0;
      m_we      = 1'b0;
      m_addr    = '0;
      m_wdata   = '0;
      m_rexp[0] = '0;
      m_rexp[1] = '0;
    end else if (m_active) begin
      if (d == 1) begin
        if (m_we) shadow[m_addr] = m_wdata;
        else      m_rexp[m_port] = shadow[m_addr];
      end else begin
        m_prio   = ~m_port;
        m_active = 1'b0;
      end
    end else if (bus.req0 || bus.req1) begin
      m_port   = (bus.req0 && bus.req1) ? m_prio : bus.req1;
      m_we     = m_port ? bus.we1 : bus.we0;
      m_addr   = m_port ? bus.addr1 : bus.addr0;
      m_wdata  = m_port ? bus.wdata1 : bus.wdata0;
      m_grant  = cyc;
      m_active = 1'b1;
    end
  endtask

  task automatic check_model();
    int d;
    d = cyc - m_grant;
    chk("busy", 32'(bus.busy), 32'(m_active));
    chk("ack0", 32'(bus.ack0), 32'(m_active && d == 2 && m_port == 1'b0));
    chk("ack1", 32'(bus.ack1), 32'(m_active && d == 2 && m_port == 1'b1));
    chk("mem_read_write", 32'(bus.mem_read_write), 32'(m_active && d == 1 && m_we));
    chk("mem_address", 32'(bus.mem_address), 32'(m_addr));
    chk("mem_data_in", 32'(bus.mem_data_in), 32'(m_wdata));
    chk("rdata0", 32'(bus.rdata0), 32'(m_rexp[0]));
    chk("rdata1", 32'(bus.rdata1), 32'(m_rexp[1]));
    if (m_active) chk("owner", 32'(bus.owner), 32'(m_port));
  endtask

  task automatic tick();
    model_advance();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.mem_read_write) rw_count++;
    check_model();
  endtask

  task automatic set_port(input bit p, input bit r, input bit w, input logic [AW-1:0] a,
                          input logic [DW-1:0] dt);
    if (p) begin
      bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = dt;
    end else begin
      bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = dt;
    end
  endtask

  // Single request from IDLE; ends one cycle after the ack, back in IDLE.
  task automatic do_req(input bit p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] dt,
                        output logic [DW-1:0] rd);
    int start;
    int lat;
    start = cyc;
    lat = -1;
    set_port(p, 1'b1, w, a, dt);
    for (int i = 0; i < 12; i++) begin
      tick();
      if ((p ? bus.ack1 : bus.ack0) === 1'b1) begin
        lat = cyc - start;
        break;
      end
    end
    chk("ack_latency", 32'(lat), 32'd2);
    rd = p ? bus.rdata1 : bus.rdata0;
    set_port(p, 1'b0, w, a, dt);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] rd;
    int a0, a1, start, n;
    int seqp [4];
    int seqc [4];

    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
    do_reset();

    // Reset values pinned by hand.
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ack", 32'({bus.ack1, bus.ack0}), 32'd0);
    chk("rst_rdata", 32'({bus.rdata1, bus.rdata0}), 32'd0);
    chk("rst_mem", 32'({bus.mem_read_write, bus.mem_address, bus.mem_data_in}), 32'd0);

    // Write then read back on port 0; exactly one write strobe.
    rw_count = 0;
    do_req(1'b0, 1'b1, 5'd5, 8'hA5, rd);
    chk("write_strobe_cycles", 32'(rw_count), 32'd1);
    do_req(1'b0, 1'b0, 5'd5, 8'h00, rd);
    chk("read_back_a5", 32'(rd), 32'hA5);

    // Simultaneous requests straight from reset: port 0 wins.
    do_reset();
    set_port(1'b0, 1'b1, 1'b1, 5'd3, 8'h11);
    set_port(1'b1, 1'b1, 1'b0, 5'd3, 8'h00);
    start = cyc; a0 = -1; a1 = -1;
    for (int i = 0; i < 12 && (a0 < 0 || a1 < 0); i++) begin
      tick();
      if (bus.ack0 === 1'b1) begin a0 = cyc; set_port(1'b0, 1'b0, 1'b0, '0, '0); end
      if (bus.ack1 === 1'b1) begin a1 = cyc; set_port(1'b1, 1'b0, 1'b0, '0, '0); end
    end
    chk("tie_ack0_latency", 32'(a0 - start), 32'd2);
    chk("tie_ack1_gap", 32'(a1 - a0), 32'd3);
    chk("tie_rdata1", 32'(bus.rdata1), 32'h11);
    tick();

    // Both held with reads: alternating acks every 3 cycles.
    set_port(1'b0, 1'b1, 1'b0, 5'd5, 8'h00);
    set_port(1'b1, 1'b1, 1'b0, 5'd3, 8'h00);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (n < 4 && bus.ack0 === 1'b1) begin seqp[n] = 0; seqc[n] = cyc; n++; end
      if (n < 4 && bus.ack1 === 1'b1) begin seqp[n] = 1; seqc[n] = cyc; n++; end
    end
    chk("rr_ack_count", 32'(n), 32'd4);
    for (int i = 0; i < 4 && i < n; i++) begin
      chk("rr_port", 32'(seqp[i]), 32'(i % 2));
      if (i > 0) chk("rr_gap", 32'(seqc[i] - seqc[i-1]), 32'd3);
    end
    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) tick();

    // Top and bottom addresses do not alias.
    do_req(1'b0, 1'b1, 5'd0, 8'h77, rd);
    do_req(1'b1, 1'b1, 5'd31, 8'hFF, rd);
    do_req(1'b0, 1'b0, 5'd31, 8'h00, rd);
    chk("addr31_read", 32'(rd), 32'hFF);
    do_req(1'b1, 1'b0, 5'd0, 8'h00, rd);
    chk("addr0_read", 32'(rd), 32'h77);

    // Reset during ACCESS of a port 1 read kills the ack and clears rdata1.
    set_port(1'b1, 1'b1, 1'b0, 5'd31, 8'h00);
    tick();
    chk("pre_reset_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
    chk("reset_no_ack1", 32'(bus.ack1), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_rdata1", 32'(bus.rdata1), 32'd0);
    tick();
    do_req(1'b1, 1'b0, 5'd31, 8'h00, rd);
    chk("post_reset_read", 32'(rd), 32'hFF);

    // A write does not disturb the held read data.
    do_req(1'b1, 1'b1, 5'd9, 8'h5A, rd);
    do_req(1'b0, 1'b0, 5'd9, 8'h00, rd);
    chk("read_5a", 32'(rd), 32'h5A);
    do_req(1'b0, 1'b1, 5'd10, 8'h3C, rd);
    chk("rdata0_kept", 32'(bus.rdata0), 32'h5A);

    // Random traffic with occasional resets, checked every cycle by the model.
    for (int i = 0; i < 800; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!(p == 1 ? bus.req1 : bus.req0) && $urandom_range(1, 0) == 1)
          set_port(p[0], 1'b1, $urandom_range(1, 0) == 1, AW'($urandom_range(31, 0)),
                   DW'($urandom_range(255, 0)));
      end
      reset = ($urandom_range(149, 0) == 0);
      tick();
      for (int p = 0; p < 2; p++) begin
        if ((p == 1 ? bus.ack1 : bus.ack0) === 1'b1) begin
          if ($urandom_range(2, 0) == 0)
            set_port(p[0], 1'b1, $urandom_range(1, 0) == 1, AW'($urandom_range(31, 0)),
                     DW'($urandom_range(255, 0)));
          else
            set_port(p[0], 1'b0, 1'b0, '0, '0);
        end
      end
    end
    reset = 1'b0;
    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
